// File: rtl/ysyx_220066_pkg.sv
// Shared types and defaults for the ysyx_220066 memory arbiter.
// Owner encoding doubles as the grant index (IFU=0, LSU=1).
package ysyx_220066_pkg;

  localparam int ADDR_W_DEF   = 64;
  localparam int DATA_W_DEF   = 64;
  localparam int MAX_WAIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/ysyx_220066_arb_pick.sv
// Grant selection between IFU and LSU: LSU has fixed priority, but once IFU
// has lost MAX_WAIT arbitrations in a row while waiting it is forced to win.
module ysyx_220066_arb_pick
  import ysyx_220066_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           idle,
  input  logic                           ifu_valid,
  input  logic                           lsu_valid,
  output logic                           ifu_grant,
  output logic                           lsu_grant,
  output owner_t                         owner,
  output logic [$clog2(MAX_WAIT+1)-1:0]  wait_cnt
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic force_ifu;

  // A grant is only ever given to a valid requester, so grant == handshake.
  always_comb begin
    force_ifu = (wait_cnt == CNT_MAX) && ifu_valid;
    ifu_grant = 1'b0;
    lsu_grant = 1'b0;
    if (idle) begin
      if (force_ifu) begin
        ifu_grant = 1'b1;
      end else if (lsu_valid) begin
        lsu_grant = 1'b1;
      end else if (ifu_valid) begin
        ifu_grant = 1'b1;
      end
    end
  end

  assign owner = lsu_grant ? OWN_LSU : OWN_IFU;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (ifu_grant) begin
      wait_cnt <= '0;
    end else if (lsu_grant && ifu_valid && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ysyx_220066_mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory arbiter, one transaction in flight.
// Request flow: IDLE grant -> ISSUE to memory -> WAIT for response -> RESP pulse.
module ysyx_220066_mem_arbiter
  import ysyx_220066_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  // fetch port
  input  logic                           ifu_req_valid,
  output logic                           ifu_req_ready,
  input  logic [ADDR_W-1:0]              ifu_addr,
  output logic                           ifu_resp_valid,
  output logic [DATA_W-1:0]              ifu_resp_data,
  // load/store port
  input  logic                           lsu_req_valid,
  output logic                           lsu_req_ready,
  input  logic [ADDR_W-1:0]              lsu_addr,
  input  logic                           lsu_wen,
  input  logic [DATA_W-1:0]              lsu_wdata,
  input  logic [DATA_W/8-1:0]            lsu_wmask,
  output logic                           lsu_resp_valid,
  output logic [DATA_W-1:0]              lsu_resp_data,
  // memory port
  output logic                           mem_req_valid,
  input  logic                           mem_req_ready,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic                           mem_wen,
  output logic [DATA_W-1:0]              mem_wdata,
  output logic [DATA_W/8-1:0]            mem_wmask,
  input  logic                           mem_resp_valid,
  input  logic [DATA_W-1:0]              mem_resp_data,
  // status / debug
  output logic                           busy,
  output logic                           err,
  output logic [1:0]                     dbg_state,
  output logic [$clog2(MAX_WAIT+1)-1:0]  dbg_wait_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // A valid never waits on ready; ready here depends only on state, the
  // request valids and the IFU wait count.

  arb_state_t            state, state_nxt;
  owner_t                owner_q, pick_owner;
  logic [ADDR_W-1:0]     addr_q;
  logic                  wen_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wmask_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  err_q;
  logic                  ifu_grant, lsu_grant, accept, resp_take;

  ysyx_220066_arb_pick #(
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .clk       (clk),
    .rst       (rst),
    .idle      (state == ST_IDLE),
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
    .ifu_grant (ifu_grant),
    .lsu_grant (lsu_grant),
    .owner     (pick_owner),
    .wait_cnt  (dbg_wait_cnt)
  );

  assign accept    = ifu_grant | lsu_grant;
  assign resp_take = (state == ST_WAIT) && mem_resp_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)        state_nxt = ST_ISSUE;
      ST_ISSUE: if (mem_req_ready) state_nxt = ST_WAIT;
      ST_WAIT:  if (mem_resp_valid) state_nxt = ST_RESP;
      ST_RESP:                     state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      owner_q <= OWN_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner_q <= pick_owner;
        if (pick_owner == OWN_LSU) begin
          addr_q  <= lsu_addr;
          wen_q   <= lsu_wen;
          wdata_q <= lsu_wdata;
          wmask_q <= lsu_wmask;
        end else begin
          addr_q  <= ifu_addr;
          wen_q   <= 1'b0;
          wdata_q <= '0;
          wmask_q <= '0;
        end
      end
      if (resp_take) begin
        rdata_q <= mem_resp_data;
      end
      // Any response outside WAIT has no owner; it is dropped and flagged.
      if (mem_resp_valid && (state != ST_WAIT)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ifu_req_ready  = ifu_grant;
  assign lsu_req_ready  = lsu_grant;

  assign mem_req_valid  = (state == ST_ISSUE);
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;

  // Responses come from registers only, so no mem_* input reaches them combinationally.
  assign ifu_resp_valid = (state == ST_RESP) && (owner_q == OWN_IFU);
  assign lsu_resp_valid = (state == ST_RESP) && (owner_q == OWN_LSU);
  assign ifu_resp_data  = rdata_q;
  assign lsu_resp_data  = rdata_q;

  assign busy      = (state != ST_IDLE);
  assign err       = err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_ysyx_220066_mem_arbiter.sv
// Bench for ysyx_220066_mem_arbiter: transaction-level model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_ysyx_220066_mem_arbiter;
  import ysyx_220066_pkg::*;

  localparam int AW       = 64;
  localparam int DW       = 64;
  localparam int MW       = DW / 8;
  localparam int MAX_WAIT = 4;
  localparam int CW       = $clog2(MAX_WAIT + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          ifu_req_valid = 1'b0;
  logic          ifu_req_ready;
  logic [AW-1:0] ifu_addr = '0;
  logic          ifu_resp_valid;
  logic [DW-1:0] ifu_resp_data;
  logic          lsu_req_valid = 1'b0;
  logic          lsu_req_ready;
  logic [AW-1:0] lsu_addr = '0;
  logic          lsu_wen = 1'b0;
  logic [DW-1:0] lsu_wdata = '0;
  logic [MW-1:0] lsu_wmask = '0;
  logic          lsu_resp_valid;
  logic [DW-1:0] lsu_resp_data;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic          busy, err;
  logic [1:0]    dbg_state;
  logic [CW-1:0] dbg_wait_cnt;

  ysyx_220066_mem_arbiter #(
    .ADDR_W (AW), .DATA_W (DW), .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_data  (ifu_resp_data),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_data  (lsu_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .busy           (busy),
    .err            (err),
    .dbg_state      (dbg_state),
    .dbg_wait_cnt   (dbg_wait_cnt)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- memory side ----------------
  bit            mem_auto = 1'b1;
  int            mem_stall = 0;
  int            mem_lat = 1;
  logic          auto_ready = 1'b0, auto_rv = 1'b0;
  logic [DW-1:0] auto_data = '0;
  logic          man_ready = 1'b0, man_rv = 1'b0;
  logic [DW-1:0] man_data = '0;

  assign mem_req_ready  = auto_ready | man_ready;
  assign mem_resp_valid = auto_rv | man_rv;
  assign mem_resp_data  = man_rv ? man_data : auto_data;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 64'h8000_0000) return 64'h0000_0013_0000_0093;
    return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
  endfunction

  initial begin : mem_responder
    logic [AW-1:0] a;
    forever begin
      @(posedge clk); #1;
      if (mem_auto && mem_req_valid) begin
        a = mem_addr;
        repeat (mem_stall) begin @(posedge clk); #1; end
        auto_ready = 1'b1;
        @(posedge clk); #1;
        auto_ready = 1'b0;
        repeat (mem_lat - 1) begin @(posedge clk); #1; end
        auto_rv   = 1'b1;
        auto_data = mem_word(a);
        @(posedge clk); #1;
        auto_rv   = 1'b0;
      end
    end
  end

  // ---------------- transaction-level model + per-cycle compare ----------------
  // One transaction record with timestamps: accepted, memory-accepted,
  // response cycle. Expected outputs follow from the timing rules.
  bit            m_active = 1'b0;
  bit            m_owner = 1'b0;      // 0 IFU, 1 LSU
  logic [AW-1:0] m_addr = '0;
  bit            m_wen = 1'b0;
  logic [DW-1:0] m_wdata = '0;
  logic [MW-1:0] m_wmask = '0;
  bit            m_mem_done = 1'b0;
  int            m_resp_at = -1;
  int            m_wcnt = 0;
  bit            m_err = 1'b0;
  logic [DW-1:0] exp_q[$];

  always @(negedge clk) begin : model_p
    bit         ifu_w, lsu_w, resp_now;
    logic [1:0] exp_st;
    if (chk_en) begin
      ifu_w    = !m_active && ifu_req_valid && ((m_wcnt == MAX_WAIT) || !lsu_req_valid);
      lsu_w    = !m_active && lsu_req_valid && !ifu_w;
      resp_now = m_active && (m_resp_at == cyc);
      if (!m_active)        exp_st = ST_IDLE;
      else if (!m_mem_done) exp_st = ST_ISSUE;
      else if (resp_now)    exp_st = ST_RESP;
      else                  exp_st = ST_WAIT;

      chk("ifu_req_ready", ifu_req_ready, ifu_w);
      chk("lsu_req_ready", lsu_req_ready, lsu_w);
      chk("busy", busy, m_active);
      chk("err", err, m_err);
      chk("wait_cnt", dbg_wait_cnt, m_wcnt);
      chk("state", dbg_state, exp_st);
      chk("mem_req_valid", mem_req_valid, m_active && !m_mem_done);
      if (m_active && !m_mem_done) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wen", mem_wen, m_wen);
        chk("mem_wmask", mem_wmask, m_wmask);
        if (m_wen) chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("ifu_resp_valid", ifu_resp_valid, resp_now && !m_owner);
      chk("lsu_resp_valid", lsu_resp_valid, resp_now && m_owner);
      if (resp_now) begin
        if (m_owner) chk("lsu_resp_data", lsu_resp_data, exp_q[0]);
        else         chk("ifu_resp_data", ifu_resp_data, exp_q[0]);
      end

      // advance the model to the state after the coming edge
      if (!rst) begin
        m_active = 1'b0; m_mem_done = 1'b0; m_resp_at = -1;
        m_wcnt = 0; m_err = 1'b0; exp_q.delete();
      end else begin
        if (mem_resp_valid) begin
          if (m_active && m_mem_done && (m_resp_at < 0)) begin
            m_resp_at = cyc + 1;
            exp_q.push_back(mem_resp_data);
          end else begin
            m_err = 1'b1;
          end
        end
        if (resp_now) begin
          m_active = 1'b0;
          void'(exp_q.pop_front());
        end else if (m_active && !m_mem_done && mem_req_ready) begin
          m_mem_done = 1'b1;
        end else if (ifu_w || lsu_w) begin
          m_active = 1'b1; m_mem_done = 1'b0; m_resp_at = -1;
          m_owner  = lsu_w;
          m_addr   = lsu_w ? lsu_addr : ifu_addr;
          m_wen    = lsu_w ? lsu_wen : 1'b0;
          m_wdata  = lsu_w ? lsu_wdata : '0;
          m_wmask  = lsu_w ? lsu_wmask : '0;
          if (ifu_w) m_wcnt = 0;
          else if (ifu_req_valid && (m_wcnt < MAX_WAIT)) m_wcnt = m_wcnt + 1;
        end
      end
    end
  end

  // ---------------- observation log for directed checks ----------------
  int            ifu_resp_n = 0, lsu_resp_n = 0, memv_n = 0, memwen_n = 0;
  int            last_ifu_cyc = 0;
  logic [DW-1:0] last_ifu_data = '0;
  bit            obs_grant_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      if (ifu_resp_valid) begin
        ifu_resp_n++; last_ifu_cyc = cyc; last_ifu_data = ifu_resp_data;
      end
      if (lsu_resp_valid) lsu_resp_n++;
      if (mem_req_valid) begin
        memv_n++;
        if (mem_wen) memwen_n++;
      end
      if (rst && ifu_req_valid && ifu_req_ready) obs_grant_q.push_back(1'b0);
      if (rst && lsu_req_valid && lsu_req_ready) obs_grant_q.push_back(1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic ifu_read(input logic [AW-1:0] a, output int acc);
    int n = 0;
    acc = -1;
    ifu_addr = a;
    ifu_req_valid = 1'b1;
    while ((acc < 0) && (n < 200)) begin
      @(negedge clk);
      if (rst && ifu_req_ready) acc = cyc;
      n++;
    end
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    chk("ifu handshake seen", acc >= 0, 1'b1);
  endtask

  task automatic lsu_op(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd,
                        input logic [MW-1:0] wm, output int acc);
    int n = 0;
    acc = -1;
    lsu_addr = a; lsu_wen = we; lsu_wdata = wd; lsu_wmask = wm;
    lsu_req_valid = 1'b1;
    while ((acc < 0) && (n < 200)) begin
      @(negedge clk);
      if (rst && lsu_req_ready) acc = cyc;
      n++;
    end
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
    chk("lsu handshake seen", acc >= 0, 1'b1);
  endtask

  task automatic settle(input int extra);
    int n = 0;
    @(negedge clk);
    while (busy && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    chk("settle idle", busy, 1'b0);
    repeat (extra) @(posedge clk);
    @(posedge clk); #1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : main
    int a0, a1, first_l, n0, n1, g0, v0, w0;
    bit exp_g[7];
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset err", err, 1'b0);
    chk("reset mem_req_valid", mem_req_valid, 1'b0);
    chk("reset ifu_resp_valid", ifu_resp_valid, 1'b0);
    chk("reset lsu_resp_valid", lsu_resp_valid, 1'b0);
    chk("reset wait_cnt", dbg_wait_cnt, 0);
    @(posedge clk); #1;

    // lone IFU fetch, s=0 k=1
    n0 = ifu_resp_n; n1 = lsu_resp_n;
    ifu_read(64'h8000_0000, a0);
    settle(0);
    chk("t1 ifu resp count", ifu_resp_n - n0, 1);
    chk("t1 ifu resp latency", last_ifu_cyc - a0, 3);
    chk("t1 ifu resp data", last_ifu_data, 64'h0000_0013_0000_0093);
    chk("t1 lsu resp count", lsu_resp_n - n1, 0);

    // simultaneous requests: LSU first, IFU in the IDLE after
    fork
      ifu_read(64'h8000_0040, a0);
      lsu_op(64'h8000_1000, 1'b0, '0, '0, a1);
    join
    settle(0);
    chk("t2 lsu first", a1 < a0, 1'b1);
    chk("t2 ifu accept gap", a0 - a1, 4);
    chk("t2 wait_cnt back to 0", dbg_wait_cnt, 0);

    // starvation guard: 4 LSU wins then IFU forced
    g0 = obs_grant_q.size();
    first_l = -1;
    fork
      ifu_read(64'h8000_0100, a0);
      begin
        for (int i = 0; i < 6; i++) begin
          lsu_op(64'h8000_1100 + 64'(i * 8), 1'b0, '0, '0, a1);
          if (i == 0) first_l = a1;
        end
      end
    join
    settle(1);
    chk("t3 grant count", obs_grant_q.size() - g0, 7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("t3 grant %0d", i), obs_grant_q[g0 + i], exp_g[i]);
    chk("t3 ifu accept after 4 lsu", a0 - first_l, 16);
    chk("t3 wait_cnt end", dbg_wait_cnt, 0);

    // store with 3 stall cycles
    mem_stall = 3;
    v0 = memv_n; w0 = memwen_n; n1 = lsu_resp_n;
    lsu_op(64'h8000_2004, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 8'hF0, a1);
    settle(0);
    mem_stall = 0;
    chk("t4 mem_req_valid cycles", memv_n - v0, 4);
    chk("t4 mem_wen cycles", memwen_n - w0, 4);
    chk("t4 store ack", lsu_resp_n - n1, 1);

    // reset during WAIT, then an orphan response in IDLE
    mem_auto = 1'b0;
    n0 = ifu_resp_n; n1 = lsu_resp_n;
    lsu_op(64'h8000_3000, 1'b0, '0, '0, a1);
    man_ready = 1'b1;
    @(posedge clk); #1;
    man_ready = 1'b0;
    @(negedge clk);
    chk("t5 in wait", dbg_state, ST_WAIT);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("t5 busy after reset", busy, 1'b0);
    chk("t5 lsu_resp_valid after reset", lsu_resp_valid, 1'b0);
    chk("t5 err after reset", err, 1'b0);
    @(posedge clk); #1;
    man_data = 64'h1234_5678_9ABC_DEF0;
    man_rv = 1'b1;
    @(posedge clk); #1;
    man_rv = 1'b0;
    @(negedge clk);
    chk("t5 err after orphan", err, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("t5 no lsu response", lsu_resp_n - n1, 0);
    chk("t5 no ifu response", ifu_resp_n - n0, 0);
    mem_auto = 1'b1;

    // err is sticky across normal traffic
    ifu_read(64'h8000_0000, a0);
    settle(0);
    chk("t6 ifu data", last_ifu_data, 64'h0000_0013_0000_0093);
    lsu_op(64'h8000_2008, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h0F, a1);
    settle(0);
    chk("t6 err sticky", err, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
